golden_nonce_framer: RTL and testbench

GOLDEN_NONCE_FRAMER -- requirements
Module: golden_nonce_framer

---
 rtl/golden_nonce_pkg.sv | 38 +++
 rtl/nonce_fifo.sv | 73 +++++++
 rtl/golden_nonce_framer.sv | 148 ++++++++++++++
 tb/tb_golden_nonce_framer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/golden_nonce_pkg.sv
// golden_nonce_pkg
// Shared definitions for the golden-nonce framer: frame magic, frame field
// offsets, the queued entry layout and the framer FSM state encoding.
// Compile-time option used by the framer: NONCE_DEDUP_EN.
package golden_nonce_pkg;

  localparam logic [15:0] MAGIC = 16'hA55A;

  // Frame layout, MSB first: {MAGIC, job_id, nonce}
  localparam int MAGIC_MSB = 63;
  localparam int MAGIC_LSB = 48;
  localparam int JOB_MSB   = 47;
  localparam int JOB_LSB   = 32;
  localparam int NONCE_MSB = 31;
  localparam int NONCE_LSB = 0;

  // One queued result; 48 bits, same order as the low part of the frame.
  typedef struct packed {
    logic [15:0] job_id;
    logic [31:0] nonce;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    GAP_WAIT = 2'd2
  } state_e;

  function automatic logic [63:0] build_frame(input entry_t e);
    logic [63:0] f;
    f                      = '0;
    f[MAGIC_MSB:MAGIC_LSB] = MAGIC;
    f[JOB_MSB:JOB_LSB]     = e.job_id;
    f[NONCE_MSB:NONCE_LSB] = e.nonce;
    return f;
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// nonce_fifo
// Single-clock result FIFO, DEPTH x 48-bit entries. Head entry is presented
// combinationally on rdata_o. A push while full is only honoured when a pop
// happens in the same cycle (the slot being freed is reused).
// Ports:
//   clk_i, rst_n_i      clock, async active-low reset
//   push_i / wdata_i    write request and entry
//   pop_i  / rdata_o    read request and head entry
//   full_o, empty_o     occupancy flags
//   count_o             entries currently stored (post-edge)
module nonce_fifo
  import golden_nonce_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  entry_t                 wdata_i,
  input  logic                   pop_i,
  output entry_t                 rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // DEPTH is a power of two, so pointers wrap by natural overflow
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (!wr_en && rd_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; entries are only visible through count_q.
  // On a full push+pop the write lands in the slot being read this cycle,
  // which is safe because the read is of the pre-edge contents.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/golden_nonce_framer.sv
// golden_nonce_framer
// Queues golden nonces from the hashing core and hands them to the MIPI TX
// side as 64-bit frames {MAGIC, job_id, nonce}, one at a time, with at least
// GAP idle cycles after each accepted frame.
// Ports:
//   hash_clk, rst_n        sole clock, async active-low reset
//   nonce_valid/nonce/job_id  one-cycle result strobe and payload
//   out_ready              TX can accept (only looked at while presenting)
//   out_valid/out_data     frame handshake; out_data holds last frame when idle
//   fifo_count             queued entries (excludes the frame being presented)
//   drop_count/overflow    saturating loss counter and sticky loss flag
// Build option: define NONCE_DEDUP_EN to silently discard a push identical
// to the last accepted entry.
module golden_nonce_framer
  import golden_nonce_pkg::*;
#(
  parameter int DEPTH = 4,   // power of two, 2..16
  parameter int GAP   = 32   // 1..255
) (
  input  logic                   hash_clk,
  input  logic                   rst_n,
  input  logic                   nonce_valid,
  input  logic [31:0]            nonce,
  input  logic [15:0]            job_id,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [63:0]            out_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             drop_count,
  output logic                   overflow
);

  localparam logic [7:0] GAP_RELOAD = 8'(GAP - 1);

  state_e      state_q, state_d;
  logic [7:0]  gap_q, gap_d;
  logic [63:0] out_data_q, out_data_d;
  logic [7:0]  drop_q, drop_d;
  logic        ovf_q, ovf_d;

  entry_t      in_entry, head;
  logic        fifo_full, fifo_empty;
  logic        pop, push, drop, dup;

  assign in_entry = {job_id, nonce};

`ifdef NONCE_DEDUP_EN
  // Last accepted entry; the valid bit keeps an all-zero first push from
  // being mistaken for a repeat right after reset.
  entry_t last_q;
  logic   last_vld_q;

  assign dup = nonce_valid && last_vld_q && (in_entry == last_q);

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (push) begin
      last_q     <= in_entry;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // The pop frees a slot this cycle, so a full FIFO can still take a push.
  assign push = nonce_valid && !dup && (!fifo_full || pop);
  assign drop = nonce_valid && !dup && fifo_full && !pop;

  nonce_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (hash_clk),
    .rst_n_i (rst_n),
    .push_i  (push),
    .wdata_i (in_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Frame FSM
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    out_data_d = out_data_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          out_data_d = build_frame(head);
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_d = GAP_WAIT;
          gap_d   = GAP_RELOAD;
        end
      end
      GAP_WAIT: begin
        // GAP cycles here plus one IDLE pop cycle give GAP+2 spacing
        if (gap_q == 8'd0) state_d = IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: begin
        state_d = IDLE;
        gap_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_q      <= 8'd0;
      out_data_q <= '0;
      drop_q     <= 8'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      out_data_q <= out_data_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid  = (state_q == PRESENT);
  assign out_data   = out_data_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_golden_nonce_framer.sv
module tb_golden_nonce_framer;

  localparam int DEPTH = 4;
  localparam int GAP   = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          hash_clk;
  logic          rst_n;
  logic          nonce_valid;
  logic [31:0]   nonce;
  logic [15:0]   job_id;
  logic          out_ready;
  logic          out_valid;
  logic [63:0]   out_data;
  logic [CW-1:0] fifo_count;
  logic [7:0]    drop_count;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  golden_nonce_framer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .hash_clk    (hash_clk),
    .rst_n       (rst_n),
    .nonce_valid (nonce_valid),
    .nonce       (nonce),
    .job_id      (job_id),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .fifo_count  (fifo_count),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  function automatic logic [63:0] fr(input logic [15:0] j, input logic [31:0] n);
    return {16'hA55A, j, n};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] n, input logic [15:0] j);
    nonce_valid = 1'b1;
    nonce       = n;
    job_id      = j;
    tick();
    nonce_valid = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (!out_valid && n < maxc) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int seen;
    rst_n       = 1'b0;
    nonce_valid = 1'b0;
    nonce       = '0;
    job_id      = '0;
    out_ready   = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data",  out_data, 64'(0));
    chk("rst_count", 64'(fifo_count), 64'(0));
    chk("rst_drop",  64'(drop_count), 64'(0));
    chk("rst_ovf",   64'(overflow), 64'(0));
    rst_n = 1'b1;
    tick();

    // single frame, 2-cycle latency, one cycle wide with ready held
    out_ready   = 1'b1;
    nonce_valid = 1'b1;
    nonce       = 32'hDEADBEEF;
    job_id      = 16'h0012;
    tick();
    nonce_valid = 1'b0;
    chk("lat1_valid", 64'(out_valid), 64'(0));
    chk("lat1_count", 64'(fifo_count), 64'(1));
    tick();
    chk("lat2_valid", 64'(out_valid), 64'(1));
    chk("lat2_data",  out_data, 64'hA55A0012DEADBEEF);
    chk("lat2_count", 64'(fifo_count), 64'(0));
    tick();
    chk("one_wide",  64'(out_valid), 64'(0));
    chk("hold_data", out_data, 64'hA55A0012DEADBEEF);

    // back-pressure: frame stays stable while out_ready low
    out_ready = 1'b0;
    push(32'hCAFEF00D, 16'h0034);
    wait_valid(100, n);
    chk("stall_present", 64'(out_valid), 64'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_data",  out_data, fr(16'h0034, 32'hCAFEF00D));
    end
    out_ready = 1'b1;
    tick();
    chk("stall_release", 64'(out_valid), 64'(0));

    // overflow: 6 pushes during the gap into a 4-deep FIFO
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) push(32'(k), 16'h0035);
    chk("ovf_count", 64'(fifo_count), 64'(4));
    chk("ovf_drop",  64'(drop_count), 64'(2));
    chk("ovf_flag",  64'(overflow), 64'(1));
    wait_valid(100, n);
    chk("ovf_f1_valid", 64'(out_valid), 64'(1));
    chk("ovf_f1_data",  out_data, fr(16'h0035, 32'd1));
    chk("ovf_f1_count", 64'(fifo_count), 64'(3));
    out_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      n = 1;
      while (!out_valid && n < 200) begin
        tick();
        n++;
      end
      chk("spacing", 64'(n), 64'(GAP + 2));
      chk("order_data", out_data, fr(16'h0035, 32'(k)));
      chk("order_count", 64'(fifo_count), 64'(4 - k));
    end
    tick();
    chk("drain_valid", 64'(out_valid), 64'(0));
    chk("drain_count", 64'(fifo_count), 64'(0));
    chk("drain_drop",  64'(drop_count), 64'(2));

    // push while full in the same cycle as the pop out of IDLE
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(32'h10 + 32'(k), 16'h0036);
    repeat (28) tick();
    chk("pp_pre_count", 64'(fifo_count), 64'(4));
    chk("pp_pre_valid", 64'(out_valid), 64'(0));
    push(32'h77, 16'h0036);
    chk("pp_valid", 64'(out_valid), 64'(1));
    chk("pp_count", 64'(fifo_count), 64'(4));
    chk("pp_drop",  64'(drop_count), 64'(2));
    chk("pp_data",  out_data, fr(16'h0036, 32'h10));

    // asynchronous reset while presenting with entries queued
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_count", 64'(fifo_count), 64'(0));
    chk("arst_data",  out_data, 64'(0));
    chk("arst_drop",  64'(drop_count), 64'(0));
    chk("arst_ovf",   64'(overflow), 64'(0));
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("arst_no_frame", 64'(seen), 64'(0));
    push(32'hABCD0001, 16'h0037);
    chk("post_rst_count", 64'(fifo_count), 64'(1));
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'(1));
    chk("post_rst_data",  out_data, fr(16'h0037, 32'hABCD0001));
    tick();

    // identical back-to-back pushes
    push(32'h00000005, 16'h0001);
    push(32'h00000005, 16'h0001);
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (out_valid) seen++;
    end
`ifdef NONCE_DEDUP_EN
    chk("dedup_frames", 64'(seen), 64'(1));
`else
    chk("dedup_frames", 64'(seen), 64'(2));
`endif
    chk("dedup_drop",  64'(drop_count), 64'(0));
    chk("dedup_count", 64'(fifo_count), 64'(0));
    chk("dedup_data",  out_data, fr(16'h0001, 32'h5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
